// File: rtl/g_2strb_drv.sv
// Two-channel active-low strobe driver: non-overlapping fixed-width strobes on AN/BN with a recovery gap.
// Optional sticky request-overflow flag enabled by defining G_2STRB_DRV_OVF_EN.
//
// state   | meaning
// IDLE    | no strobe active, waiting for an eligible request
// PULSE_A | AN held low, counter runs down the pulse width
// PULSE_B | BN held low, counter runs down the pulse width
// GAP     | both strobes high, counter runs down the recovery gap
module g_2strb_drv #(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQA,
  input  logic REQB,
  output logic AN,
  output logic BN,
  output logic BUSY,
  output logic DONE,
  output logic OVF
);

  typedef enum logic [1:0] {IDLE, PULSE_A, PULSE_B, GAP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_a, pend_b, pend_a_nxt, pend_b_nxt;
  logic             prio_b, prio_b_nxt;
  logic             elig_a, elig_b;
  logic             grant_a, grant_b, can_grant, done_nxt;

  assign elig_a = pend_a | REQA;
  assign elig_b = pend_b | REQB;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    prio_b_nxt = prio_b;
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    can_grant  = 1'b0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: can_grant = 1'b1;
      PULSE_A, PULSE_B: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CNT_W'(GAP_LEN - 1);
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        if (cnt == '0) begin
          can_grant = 1'b1;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Priority only toggles when both channels contend for the same grant slot.
    if (can_grant) begin
      if (elig_a && elig_b) begin
        grant_a    = ~prio_b;
        grant_b    = prio_b;
        prio_b_nxt = ~prio_b;
      end else begin
        grant_a = elig_a;
        grant_b = elig_b;
      end
    end
    if (grant_a) begin
      state_nxt = PULSE_A;
      cnt_nxt   = CNT_W'(PULSE_LEN - 1);
    end else if (grant_b) begin
      state_nxt = PULSE_B;
      cnt_nxt   = CNT_W'(PULSE_LEN - 1);
    end

    // A request that alone triggers the grant is consumed; one on top of a held flag re-arms it.
    pend_a_nxt = grant_a ? (pend_a & REQA) : (pend_a | REQA);
    pend_b_nxt = grant_b ? (pend_b & REQB) : (pend_b | REQB);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      pend_a <= 1'b0;
      pend_b <= 1'b0;
      prio_b <= 1'b0;
      AN     <= 1'b1;
      BN     <= 1'b1;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      pend_a <= pend_a_nxt;
      pend_b <= pend_b_nxt;
      prio_b <= prio_b_nxt;
      AN     <= (state_nxt != PULSE_A);
      BN     <= (state_nxt != PULSE_B);
      BUSY   <= (state_nxt != IDLE);
      DONE   <= done_nxt;
    end
  end

`ifdef G_2STRB_DRV_OVF_EN
  logic ovf_set;
  assign ovf_set = (REQA & pend_a & ~grant_a) | (REQB & pend_b & ~grant_b);

  always_ff @(posedge CLK) begin
    if (RST) OVF <= 1'b0;
    else if (ovf_set) OVF <= 1'b1;
  end
`else
  assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_g_2strb_drv.sv
// Scoreboard bench for g_2strb_drv: two instances (GAP_LEN 1 and 2) checked against a strobe-timeline model.
// Follows G_2STRB_DRV_OVF_EN for the expected OVF behaviour.
module tb_g_2strb_drv;

  localparam int PL = 4;
`ifdef G_2STRB_DRV_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1, reqa = 1'b0, reqb = 1'b0;
  logic an0, bn0, busy0, done0, ovf0;
  logic an1, bn1, busy1, done1, ovf1;

  always #5 clk = ~clk;

  g_2strb_drv #(.PULSE_LEN(PL), .GAP_LEN(1), .CNT_W(8)) u_g1 (
    .CLK(clk), .RST(rst), .REQA(reqa), .REQB(reqb),
    .AN(an0), .BN(bn0), .BUSY(busy0), .DONE(done0), .OVF(ovf0));

  g_2strb_drv #(.PULSE_LEN(PL), .GAP_LEN(2), .CNT_W(8)) u_g2 (
    .CLK(clk), .RST(rst), .REQA(reqa), .REQB(reqb),
    .AN(an1), .BN(bn1), .BUSY(busy1), .DONE(done1), .OVF(ovf1));

  // Model: each channel's strobe is described by its start edge; outputs follow from edge arithmetic.
  int gl[2] = '{1, 2};
  int last[2];
  bit chb[2], pa[2], pb[2], prio_b[2], ovf[2];
  int k = 0;
  logic [4:0] q0[$], q1[$];
  int n_chk = 0, n_pass = 0;

  task automatic model_edge(input int i, input bit r, input bit a, input bit b, output logic [4:0] e);
    bit ela, elb, ga, gb, inp;
    ga = 1'b0; gb = 1'b0;
    if (r) begin
      pa[i] = 1'b0; pb[i] = 1'b0; prio_b[i] = 1'b0; ovf[i] = 1'b0; last[i] = -1000; chb[i] = 1'b0;
    end else begin
      ela = pa[i] | a;
      elb = pb[i] | b;
      if (k >= last[i] + PL + gl[i] && (ela || elb)) begin
        if (ela && elb) begin
          ga = !prio_b[i]; gb = prio_b[i]; prio_b[i] = !prio_b[i];
        end else begin
          ga = ela; gb = elb;
        end
        last[i] = k;
        chb[i]  = gb;
      end
      if (OVF_EN && ((a && pa[i] && !ga) || (b && pb[i] && !gb))) ovf[i] = 1'b1;
      pa[i] = ga ? (pa[i] && a) : (pa[i] || a);
      pb[i] = gb ? (pb[i] && b) : (pb[i] || b);
    end
    inp = (k >= last[i]) && (k < last[i] + PL);
    e = {!(inp && !chb[i]), !(inp && chb[i]),
         (k >= last[i]) && (k < last[i] + PL + gl[i]),
         (k == last[i] + PL), ovf[i]};
  endtask

  task automatic step(input bit r, input bit a, input bit b);
    logic [4:0] e;
    @(negedge clk);
    rst = r; reqa = a; reqb = b;
    model_edge(0, r, a, b, e); q0.push_back(e);
    model_edge(1, r, a, b, e); q1.push_back(e);
    k++;
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s edge %0d: got {AN,BN,BUSY,DONE,OVF}=%b expected %b", name, k, got, exp);
  endtask

  // Monitor: every clock edge that followed a stimulus step presents one output vector.
  initial begin
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("out_gap1", {an0, bn0, busy0, done0, ovf0}, e);
        n_chk++;
        if (an0 | bn0) n_pass++;
        else $display("FAIL overlap_gap1 edge %0d: AN=%b BN=%b, required not both 0", k, an0, bn0);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("out_gap2", {an1, bn1, busy1, done1, ovf1}, e);
        n_chk++;
        if (an1 | bn1) n_pass++;
        else $display("FAIL overlap_gap2 edge %0d: AN=%b BN=%b, required not both 0", k, an1, bn1);
      end
    end
  end

  initial begin
    for (int j = 0; j < 3; j++) step(1'b1, 1'b0, 1'b0);
    idle(20);
    // single A request
    step(1'b0, 1'b1, 1'b0);
    idle(15);
    // contention, then a second pair while the first A strobe is active
    step(1'b0, 1'b1, 1'b1);
    idle(2);
    step(1'b0, 1'b1, 1'b1);
    idle(30);
    // B held high
    for (int j = 0; j < 30; j++) step(1'b0, 1'b0, 1'b1);
    idle(15);
    // reset in the 2nd cycle of the A strobe with B pending
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    idle(15);
    // A requests piling up during a B strobe
    step(1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b0);
    idle(20);
    step(1'b1, 1'b0, 1'b0);
    idle(5);
    // random traffic with occasional reset
    for (int j = 0; j < 600; j++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    idle(12);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (q0.size() == 0 && q1.size() == 0) n_pass++;
    else $display("FAIL drain: %0d/%0d expectations left, required 0/0", q0.size(), q1.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
